// File: rtl/apb_pkg.sv
// apb_pkg: APB bus widths, master FSM states and the registered request record.
package apb_pkg;
    localparam int PADDR_SIZE = 32;
    localparam int PDATA_SIZE = 32;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} apb_state_e;

    typedef struct packed {
        logic                    write;
        logic [PADDR_SIZE-1:0]   addr;
        logic [PDATA_SIZE-1:0]   wdata;
        logic [PDATA_SIZE/8-1:0] strb;
    } apb_req_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin one-hot grant; the search starts one past the last winner.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] grant
);
    localparam int LW = $clog2(N);

    logic [LW-1:0] last_q;
    logic [LW-1:0] idx;
    logic [LW-1:0] gidx;

    // Walk from farthest to nearest so the nearest requester after last_q wins.
    always_comb begin
        grant = '0;
        gidx  = last_q;
        idx   = '0;
        for (int i = N; i >= 1; i--) begin
            idx = LW'((int'(last_q) + i) % N);
            if (req[idx]) begin
                grant      = '0;
                grant[idx] = 1'b1;
                gidx       = idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            last_q <= LW'(N - 1);
        else if (advance && |req)
            last_q <= gidx;
    end
endmodule

// File: rtl/apb_master_arbiter.sv
// apb_master_arbiter: shares one APB master port among NUM_REQ requesters,
// round-robin arbitrated, with SETUP/ACCESS sequencing and a PREADY watchdog.
module apb_master_arbiter
    import apb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                         PCLK,
    input  logic                         PRESET,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [NUM_REQ-1:0]           req_write,
    input  logic [NUM_REQ*PADDR_SIZE-1:0] req_addr,
    input  logic [NUM_REQ*PDATA_SIZE-1:0] req_wdata,
    input  logic [NUM_REQ*PDATA_SIZE/8-1:0] req_strb,
    output logic [NUM_REQ-1:0]           rsp_valid,
    output logic [PDATA_SIZE-1:0]        rsp_rdata,
    output logic                         rsp_err,
    output logic                         PSEL,
    output logic                         PENABLE,
    output logic                         PWRITE,
    output logic [PADDR_SIZE-1:0]        PADDR,
    output logic [PDATA_SIZE-1:0]        PWDATA,
    output logic [PDATA_SIZE/8-1:0]      PSTRB,
    input  logic [PDATA_SIZE-1:0]        PRDATA,
    input  logic                         PREADY,
    input  logic                         PSLVERR
);
    localparam int SW = PDATA_SIZE / 8;
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    apb_state_e         state_q;
    apb_req_t           req_d;
    apb_req_t           req_q;
    logic [NUM_REQ-1:0] grant;
    logic [NUM_REQ-1:0] gnt_q;
    logic [NUM_REQ-1:0] rsp_valid_q;
    logic [PDATA_SIZE-1:0] rsp_rdata_q;
    logic               rsp_err_q;
    logic               psel_q;
    logic               penable_q;
    logic [CW-1:0]      cnt_q;
    logic               accept;
    logic               expire;

    // Gating with PRESET keeps a held reset from producing a phantom accept.
    assign accept = (state_q == IDLE) && |req_valid && !PRESET;
    assign expire = (TIMEOUT > 0) && (cnt_q == CW'(TIMEOUT - 1));

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .clk     (PCLK),
        .rst     (PRESET),
        .req     (req_valid),
        .advance (accept),
        .grant   (grant)
    );

    assign req_ready = accept ? grant : '0;

    // Reads carry zero data and strobes onto the bus.
    always_comb begin
        req_d = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                req_d.write = req_write[i];
                req_d.addr  = req_addr[i*PADDR_SIZE +: PADDR_SIZE];
                req_d.wdata = req_write[i] ? req_wdata[i*PDATA_SIZE +: PDATA_SIZE] : '0;
                req_d.strb  = req_write[i] ? req_strb[i*SW +: SW] : '0;
            end
        end
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q     <= IDLE;
            req_q       <= '0;
            gnt_q       <= '0;
            cnt_q       <= '0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            rsp_valid_q <= '0;
            case (state_q)
                IDLE: if (accept) begin
                    req_q   <= req_d;
                    gnt_q   <= grant;
                    cnt_q   <= '0;
                    psel_q  <= 1'b1;
                    state_q <= SETUP;
                end
                SETUP: begin
                    penable_q <= 1'b1;
                    state_q   <= ACCESS;
                end
                ACCESS: if (PREADY || expire) begin
                    psel_q      <= 1'b0;
                    penable_q   <= 1'b0;
                    state_q     <= IDLE;
                    rsp_valid_q <= gnt_q;
                    rsp_err_q   <= PREADY ? PSLVERR : 1'b1;
                    rsp_rdata_q <= (PREADY && !req_q.write) ? PRDATA : '0;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign PSEL      = psel_q;
    assign PENABLE   = penable_q;
    assign PWRITE    = req_q.write;
    assign PADDR     = req_q.addr;
    assign PWDATA    = req_q.wdata;
    assign PSTRB     = req_q.strb;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
endmodule
